// File: rtl/fpu_add_sub_align_stage.sv
// Operand-alignment front end of the FPU add/sub path: unpack, order by magnitude,
// then right-shift the smaller significand with a sticky bit. Two registered stages.
module fpu_add_sub_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int EXT_W = 27
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_data_a,
  input  logic [31:0]      i_data_b,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_sign_large,
  output logic             o_eff_sub,
  output logic             o_swap,
  output logic [EXP_W-1:0] o_exp_large,
  output logic [EXP_W-1:0] o_exp_diff,
  output logic [EXT_W-1:0] o_mant_large,
  output logic [EXT_W-1:0] o_mant_small,
  output logic             o_nan,
  output logic             o_inf
);

  localparam int SIG_W = MAN_W + 1;
  localparam int SH_W  = $clog2(EXT_W + 1);

  logic             adv1, adv2;
  logic             signA, signB;
  logic [EXP_W-1:0] expFieldA, expFieldB, expA, expB;
  logic [MAN_W-1:0] fracA, fracB;
  logic [SIG_W-1:0] sigA, sigB;
  logic [EXP_W:0]   expSub;
  logic             aExpGe, expEq, nanA, nanB, infA, infB;

  logic             s1Valid_q, s1Sign_q, s1EffSub_q, s1Swap_q, s1Nan_q, s1Inf_q;
  logic [EXP_W-1:0] s1ExpLarge_q, s1ExpDiff_q;
  logic [SIG_W-1:0] s1SigLarge_q, s1SigSmall_q;
  logic             s1Sign_d, s1EffSub_d, s1Swap_d, s1Nan_d, s1Inf_d;
  logic [EXP_W-1:0] s1ExpLarge_d, s1ExpDiff_d;
  logic [SIG_W-1:0] s1SigLarge_d, s1SigSmall_d;

  logic             s2Valid_q, s2Sign_q, s2EffSub_q, s2Swap_q, s2Nan_q, s2Inf_q;
  logic [EXP_W-1:0] s2ExpLarge_q, s2ExpDiff_q;
  logic [EXT_W-1:0] s2MantLarge_q, s2MantSmall_q;
  logic [EXT_W-1:0] extSmall, shifted, lostMask, s2MantSmall_d;
  logic [SH_W-1:0]  shamt;

  assign adv2    = !s2Valid_q || i_ready;
  assign adv1    = !s1Valid_q || adv2;
  assign o_ready = adv1;

  always_comb begin
    signA     = i_data_a[EXP_W+MAN_W];
    signB     = i_data_b[EXP_W+MAN_W] ^ i_sub;
    expFieldA = i_data_a[MAN_W +: EXP_W];
    expFieldB = i_data_b[MAN_W +: EXP_W];
    fracA     = i_data_a[MAN_W-1:0];
    fracB     = i_data_b[MAN_W-1:0];
    // Zero/denormal operands behave as exponent 1 with no hidden bit.
    expA      = (expFieldA == '0) ? EXP_W'(1) : expFieldA;
    expB      = (expFieldB == '0) ? EXP_W'(1) : expFieldB;
    sigA      = {expFieldA != '0, fracA};
    sigB      = {expFieldB != '0, fracB};
    expSub    = {1'b0, expA} + {1'b0, ~expB} + (EXP_W+1)'(1);
    aExpGe    = expSub[EXP_W];
    expEq     = aExpGe && (expSub[EXP_W-1:0] == '0);
    nanA      = (expFieldA == '1) && (fracA != '0);
    nanB      = (expFieldB == '1) && (fracB != '0);
    infA      = (expFieldA == '1) && (fracA == '0);
    infB      = (expFieldB == '1) && (fracB == '0);

    s1Swap_d     = expEq ? (sigB > sigA) : !aExpGe;
    s1EffSub_d   = i_data_a[EXP_W+MAN_W] ^ signB;
    s1Sign_d     = s1Swap_d ? signB : signA;
    s1ExpLarge_d = s1Swap_d ? expB : expA;
    s1ExpDiff_d  = aExpGe ? expSub[EXP_W-1:0] : (~expSub[EXP_W-1:0] + EXP_W'(1));
    s1SigLarge_d = s1Swap_d ? sigB : sigA;
    s1SigSmall_d = s1Swap_d ? sigA : sigB;
    s1Nan_d      = nanA || nanB || (infA && infB && s1EffSub_d);
    s1Inf_d      = !s1Nan_d && (infA || infB);
  end

  // Shifting by the full width leaves nothing but the sticky bit, which covers diff >= 27.
  always_comb begin
    shamt         = (s1ExpDiff_q >= EXP_W'(EXT_W)) ? SH_W'(EXT_W) : SH_W'(s1ExpDiff_q);
    extSmall      = {s1SigSmall_q, 3'b000};
    shifted       = extSmall >> shamt;
    lostMask      = ~({EXT_W{1'b1}} << shamt);
    s2MantSmall_d = {shifted[EXT_W-1:1], shifted[0] | (|(extSmall & lostMask))};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1Valid_q     <= 1'b0;
      s1Sign_q      <= 1'b0;
      s1EffSub_q    <= 1'b0;
      s1Swap_q      <= 1'b0;
      s1Nan_q       <= 1'b0;
      s1Inf_q       <= 1'b0;
      s1ExpLarge_q  <= '0;
      s1ExpDiff_q   <= '0;
      s1SigLarge_q  <= '0;
      s1SigSmall_q  <= '0;
      s2Valid_q     <= 1'b0;
      s2Sign_q      <= 1'b0;
      s2EffSub_q    <= 1'b0;
      s2Swap_q      <= 1'b0;
      s2Nan_q       <= 1'b0;
      s2Inf_q       <= 1'b0;
      s2ExpLarge_q  <= '0;
      s2ExpDiff_q   <= '0;
      s2MantLarge_q <= '0;
      s2MantSmall_q <= '0;
    end else begin
      if (adv1) begin
        s1Valid_q <= i_valid;
        if (i_valid) begin
          s1Sign_q     <= s1Sign_d;
          s1EffSub_q   <= s1EffSub_d;
          s1Swap_q     <= s1Swap_d;
          s1Nan_q      <= s1Nan_d;
          s1Inf_q      <= s1Inf_d;
          s1ExpLarge_q <= s1ExpLarge_d;
          s1ExpDiff_q  <= s1ExpDiff_d;
          s1SigLarge_q <= s1SigLarge_d;
          s1SigSmall_q <= s1SigSmall_d;
        end
      end
      if (adv2) begin
        s2Valid_q <= s1Valid_q;
        if (s1Valid_q) begin
          s2Sign_q      <= s1Sign_q;
          s2EffSub_q    <= s1EffSub_q;
          s2Swap_q      <= s1Swap_q;
          s2Nan_q       <= s1Nan_q;
          s2Inf_q       <= s1Inf_q;
          s2ExpLarge_q  <= s1ExpLarge_q;
          s2ExpDiff_q   <= s1ExpDiff_q;
          s2MantLarge_q <= {s1SigLarge_q, 3'b000};
          s2MantSmall_q <= s2MantSmall_d;
        end
      end
    end
  end

  assign o_valid      = s2Valid_q;
  assign o_sign_large = s2Sign_q;
  assign o_eff_sub    = s2EffSub_q;
  assign o_swap       = s2Swap_q;
  assign o_exp_large  = s2ExpLarge_q;
  assign o_exp_diff   = s2ExpDiff_q;
  assign o_mant_large = s2MantLarge_q;
  assign o_mant_small = s2MantSmall_q;
  assign o_nan        = s2Nan_q;
  assign o_inf        = s2Inf_q;

endmodule

// File: tb/tb_fpu_add_sub_align_stage.sv
// Directed bench for the FPU alignment stage: hand-computed vectors, stall and
// mid-flight reset scenarios, with an in-order scoreboard on every output transfer.
module tb_fpu_add_sub_align_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_data_a = '0;
  logic [31:0] i_data_b = '0;
  logic        i_sub = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_sign_large, o_eff_sub, o_swap, o_nan, o_inf;
  logic [7:0]  o_exp_large, o_exp_diff;
  logic [26:0] o_mant_large, o_mant_small;

  typedef struct packed {
    logic        signLarge;
    logic        effSub;
    logic        swap;
    logic [7:0]  expLarge;
    logic [7:0]  expDiff;
    logic [26:0] mantLarge;
    logic [26:0] mantSmall;
    logic        nan;
    logic        inf;
    logic        specialOnly;
  } expT;

  expT  expQ[$];
  expT  monExp;
  int   compareCount = 0;
  int   failCount = 0;
  int   recvCount = 0;
  logic sawReadyLow = 1'b0;
  logic prevStall = 1'b0;
  logic [63:0] prevSnap = '0;

  fpu_add_sub_align_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_sign_large(o_sign_large), .o_eff_sub(o_eff_sub), .o_swap(o_swap),
    .o_exp_large(o_exp_large), .o_exp_diff(o_exp_diff),
    .o_mant_large(o_mant_large), .o_mant_small(o_mant_small),
    .o_nan(o_nan), .o_inf(o_inf)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compareCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic expT mk(input logic s, input logic e, input logic sw, input logic [7:0] el,
                             input logic [7:0] ed, input logic [26:0] ml, input logic [26:0] ms,
                             input logic n, input logic i, input logic sp);
    expT r;
    r = '{signLarge: s, effSub: e, swap: sw, expLarge: el, expDiff: ed, mantLarge: ml,
          mantSmall: ms, nan: n, inf: i, specialOnly: sp};
    return r;
  endfunction

  // Scoreboard: every output transfer is matched in order against the expected queue.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      recvCount++;
      if (expQ.size() == 0) begin
        checkOutput("spuriousResult", 64'(o_valid), 64'(0));
      end else begin
        monExp = expQ.pop_front();
        checkOutput("nan", 64'(o_nan), 64'(monExp.nan));
        checkOutput("inf", 64'(o_inf), 64'(monExp.inf));
        checkOutput("signLarge", 64'(o_sign_large), 64'(monExp.signLarge));
        checkOutput("effSub", 64'(o_eff_sub), 64'(monExp.effSub));
        if (!monExp.specialOnly) begin
          checkOutput("swap", 64'(o_swap), 64'(monExp.swap));
          checkOutput("expLarge", 64'(o_exp_large), 64'(monExp.expLarge));
          checkOutput("expDiff", 64'(o_exp_diff), 64'(monExp.expDiff));
          checkOutput("mantLarge", 64'(o_mant_large), 64'(monExp.mantLarge));
          checkOutput("mantSmall", 64'(o_mant_small), 64'(monExp.mantSmall));
        end
      end
    end
  end

  // Outputs must not move while a result is held under backpressure.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prevStall = 1'b0;
    end else begin
      if (!o_ready) sawReadyLow = 1'b1;
      if (o_valid && !i_ready && prevStall)
        checkOutput("frozenOutputs", {2'b00, o_mant_small, o_mant_large, o_exp_diff},
                    prevSnap);
      prevStall = o_valid && !i_ready;
      prevSnap  = {2'b00, o_mant_small, o_mant_large, o_exp_diff};
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub,
                               input expT e);
    int n;
    i_valid  = 1'b1;
    i_data_a = a;
    i_data_b = b;
    i_sub    = sub;
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_ready && n < 50);
    if (!o_ready) checkOutput("acceptTimeout", 64'(o_ready), 64'(1));
    expQ.push_back(e);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(posedge i_clk);
      n++;
    end
    #1;
    if (expQ.size() != 0) checkOutput("drainTimeout", 64'(expQ.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int recvBefore;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rstValid", 64'(o_valid), 64'(0));
    checkOutput("rstReady", 64'(o_ready), 64'(1));
    checkOutput("rstMantLarge", 64'(o_mant_large), 64'(0));
    checkOutput("rstExpLarge", 64'(o_exp_large), 64'(0));
    @(posedge i_clk);
    #1;

    applyStimulus(32'h40400000, 32'h3F800000, 1'b0,
                  mk(0, 0, 0, 8'd128, 8'd1, 27'h6000000, 27'h2000000, 0, 0, 0));
    waitDrain();
    applyStimulus(32'h3F800000, 32'h3FC00000, 1'b1,
                  mk(1, 1, 1, 8'd127, 8'd0, 27'h6000000, 27'h4000000, 0, 0, 0));
    waitDrain();
    applyStimulus(32'h50000000, 32'h3F800001, 1'b0,
                  mk(0, 0, 0, 8'd160, 8'd33, 27'h4000000, 27'h0000001, 0, 0, 0));
    applyStimulus(32'h50000000, 32'h00000000, 1'b0,
                  mk(0, 0, 0, 8'd160, 8'd159, 27'h4000000, 27'h0000000, 0, 0, 0));
    applyStimulus(32'h4C000000, 32'h3F800001, 1'b0,
                  mk(0, 0, 0, 8'd152, 8'd25, 27'h4000000, 27'h0000003, 0, 0, 0));
    applyStimulus(32'h00000001, 32'h00800000, 1'b0,
                  mk(0, 0, 1, 8'd1, 8'd0, 27'h4000000, 27'h0000008, 0, 0, 0));
    applyStimulus(32'h7F800000, 32'h7F800000, 1'b1,
                  mk(0, 1, 0, 8'd0, 8'd0, 27'h0, 27'h0, 1, 0, 1));
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0,
                  mk(0, 0, 0, 8'd0, 8'd0, 27'h0, 27'h0, 1, 0, 1));
    applyStimulus(32'hFF800000, 32'h3F800000, 1'b0,
                  mk(1, 1, 0, 8'd0, 8'd0, 27'h0, 27'h0, 0, 1, 1));
    waitDrain();

    // Four back-to-back pairs with the consumer stalled in cycles 3..5.
    sawReadyLow = 1'b0;
    recvBefore  = recvCount;
    fork
      begin
        applyStimulus(32'h40000000, 32'h3F800000, 1'b0,
                      mk(0, 0, 0, 8'd128, 8'd1, 27'h4000000, 27'h2000000, 0, 0, 0));
        applyStimulus(32'h3F800000, 32'h40800000, 1'b0,
                      mk(0, 0, 1, 8'd129, 8'd2, 27'h4000000, 27'h1000000, 0, 0, 0));
        applyStimulus(32'hC1000000, 32'h3F800000, 1'b0,
                      mk(1, 1, 0, 8'd130, 8'd3, 27'h4000000, 27'h0800000, 0, 0, 0));
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1,
                      mk(0, 1, 0, 8'd127, 8'd0, 27'h4000000, 27'h4000000, 0, 0, 0));
      end
      begin
        for (int c = 1; c <= 8; c++) begin
          i_ready = !(c >= 3 && c <= 5);
          @(posedge i_clk);
          #1;
        end
        i_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("readyDropped", 64'(sawReadyLow), 64'(1));
    checkOutput("streamCount", 64'(recvCount - recvBefore), 64'(4));

    // Fill both stages under backpressure, then reset: nothing may emerge afterwards.
    i_ready = 1'b0;
    applyStimulus(32'h40400000, 32'h3F800000, 1'b0,
                  mk(0, 0, 0, 8'd128, 8'd1, 27'h6000000, 27'h2000000, 0, 0, 0));
    applyStimulus(32'h40000000, 32'h3F800000, 1'b0,
                  mk(0, 0, 0, 8'd128, 8'd1, 27'h4000000, 27'h2000000, 0, 0, 0));
    expQ.delete();
    i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("midRstValid", 64'(o_valid), 64'(0));
    checkOutput("midRstReady", 64'(o_ready), 64'(1));
    checkOutput("midRstMantSmall", 64'(o_mant_small), 64'(0));
    recvBefore = recvCount;
    i_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    checkOutput("noStaleResult", 64'(recvCount - recvBefore), 64'(0));
    @(posedge i_clk);
    #1;

    applyStimulus(32'h40400000, 32'h3F800000, 1'b0,
                  mk(0, 0, 0, 8'd128, 8'd1, 27'h6000000, 27'h2000000, 0, 0, 0));
    waitDrain();
    repeat (3) @(posedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/fpu_add_sub_align_stage.md
Name: fpu_add_sub_align_stage

Overview:
- Front-end operand-alignment stage of the FPU add/sub datapath used by the FFT butterflies.
- Accepts two IEEE-754 single-precision operands plus an add/sub select, and unpacks them.
- Computes the exponent difference and swaps operands so the larger magnitude sits in the "large" lane.
- Right-shifts the smaller significand with guard/round/sticky, then hands the aligned pair downstream to the mantissa adder and exponent-update logic.
- Two-stage pipeline with valid/ready flow control.

Parameters:
- EXP_W, 8, exponent field width; only 8 supported.
- MAN_W, 23, stored fraction width; only 23 supported.
- EXT_W, 27, aligned significand width: hidden bit + MAN_W + guard/round/sticky.

Ports:
- i_clk  input  1  clock; all state on rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_valid  input  1  upstream operand pair valid
- o_ready  output  1  stage can accept a pair this cycle
- i_data_a  input  32  operand A (IEEE-754 single)
- i_data_b  input  32  operand B (IEEE-754 single)
- i_sub  input  1  1 = A-B, 0 = A+B
- o_valid  output  1  aligned result valid
- i_ready  input  1  downstream accepts result
- o_sign_large  output  1  sign of the larger-magnitude operand (B's sign is flipped by i_sub first)
- o_eff_sub  output  1  effective subtraction: sign_a ^ sign_b ^ i_sub
- o_swap  output  1  1 when B was the larger magnitude
- o_exp_large  output  8  effective exponent of the larger operand
- o_exp_diff  output  8  unclamped exponent difference (large - small)
- o_mant_large  output  27  larger significand: {hidden, frac, 3'b000}
- o_mant_small  output  27  aligned smaller significand; bit0 = sticky
- o_nan  output  1  result is NaN
- o_inf  output  1  result is infinity; sign is o_sign_large

Behaviour:
- Unpacking
  - Exponent field 0 (zero/denormal): hidden bit 0, effective exponent 1.
  - Otherwise: hidden bit 1, effective exponent = field value.
- Stage 1 (S1)
  - Exponent compare via 8-bit subtraction ea + ~eb + 1.
  - Carry-out 1 means ea >= eb.
  - If exponents are equal, compare 24-bit significands; ties keep A (o_swap=0).
  - Register the swapped operands and the difference; difference is always non-negative.
- Stage 2 (S2)
  - Shift amount = min(o_exp_diff, 27).
  - o_mant_small = ({sig_small, 3'b000} >> shamt), with bit0 OR'd with every bit shifted out.
  - diff >= 27: o_mant_small = 27'd1 if sig_small != 0, else 0.
  - diff = 0: o_mant_small is the unshifted significand.
- Specials (evaluated in S1, carried through)
  - Either operand NaN (exp 255, frac != 0): o_nan=1.
  - Inf op Inf with o_eff_sub=1: o_nan=1, o_inf=0.
  - Otherwise any Inf: o_inf=1.
  - Mantissa fields are don't-care when o_nan or o_inf is set.
- Latency: 2 cycles from the accept edge to o_valid with no backpressure; throughput 1 pair/cycle.
- Handshake
  - A transfer occurs when valid && ready on the same edge.
  - adv2 = !o_valid | i_ready.
  - adv1 = !s1_valid | adv2.
  - o_ready = adv1, combinational.
  - While o_valid && !i_ready, all outputs hold stable and S1 holds if full.
  - o_ready must not depend on i_valid.
  - Simultaneous accept and emit in one cycle is allowed with no bubble.
- Reset
  - i_rst=1 at an edge clears s1_valid and o_valid, and clears all output data regs to 0.
  - o_ready = 1 during the cycle after reset.
  - In-flight pairs are discarded when reset arrives mid-operation; no partial output follows.

Test Plan:
- A=0x40400000 (3.0), B=0x3F800000 (1.0), i_sub=0 -> after 2 cycles: o_valid=1, o_swap=0, o_exp_large=128, o_exp_diff=1, o_mant_large=0x6000000, o_mant_small=0x2000000, o_eff_sub=0.
- A=0x3F800000, B=0x3FC00000, i_sub=1 -> o_swap=1, o_exp_diff=0, o_sign_large=1, o_eff_sub=1, o_mant_large=0x6000000, o_mant_small=0x4000000.
- A=0x50000000, B=0x3F800001 -> o_exp_diff=33, o_mant_small=0x0000001 (sticky only). Same with B=0x00000000 -> o_mant_small=0.
- A=0x7F800000, B=0x7F800000, i_sub=1 -> o_nan=1, o_inf=0. A=0x7FC00000, any B -> o_nan=1. A=0xFF800000, B=1.0 -> o_inf=1, o_sign_large=1.
- Stream 4 pairs back-to-back, i_ready=0 for cycles 3-5:
  - o_ready drops once S1 and S2 are both full.
  - Outputs are frozen while stalled.
  - All 4 results emerge in order with no loss or duplication.
- Two pairs in flight, assert i_rst one cycle -> o_valid=0 the next cycle, o_ready=1, no stale result ever appears.
